redundant_carry_resolver: RTL and testbench

- Sequential back end for the unsigned adder-tree multiplier.
- Accepts one frame of NUM_WORDS redundant-form words (each BIT_LEN bits wide, weight 2^(WORD_LEN*j)) in parallel.
- Emits the canonical binary value word-serially, LSW first, one WORD_LEN-bit word per handshake, propagating carries between beats.
- Replaces the wide combinational S + (C << WORD_LEN) resolution with a narrow, streaming carry chain.

---
 rtl/redundant_carry_resolver.sv | 165 ++++++++++++++++
 tb/tb_redundant_carry_resolver.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/redundant_carry_resolver.sv
// -----------------------------------------------------------------------------
// redundant_carry_resolver
//
// Sequential back end for the unsigned adder-tree multiplier. A frame of
// NUM_WORDS redundant words (BIT_LEN bits each, word j weighted by
// 2^(WORD_LEN*j)) is captured in one handshake. The canonical binary value is
// then streamed out least-significant word first, one WORD_LEN-bit word per
// output handshake. A narrow carry register links consecutive beats.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   frame present on in_words
//   in_ready   out  block can capture a frame (IDLE)
//   in_words   in   NUM_WORDS*BIT_LEN redundant words, word j at [BIT_LEN*j +: BIT_LEN]
//   out_valid  out  out_word valid
//   out_ready  in   sink accepts out_word
//   out_word   out  WORD_LEN-bit canonical word
//   out_last   out  high with the final word of the frame
//   busy       out  frame in progress
//   ovf        out  only with RESOLVER_OVF_EN: final carry of last frame was nonzero
//
// Optional feature macro: RESOLVER_OVF_EN
// -----------------------------------------------------------------------------
module redundant_carry_resolver #(
  parameter int NUM_WORDS = 34,
  parameter int BIT_LEN   = 17,
  parameter int WORD_LEN  = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [NUM_WORDS*BIT_LEN-1:0]   in_words,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [WORD_LEN-1:0]            out_word,
  output logic                           out_last,
  output logic                           busy
`ifdef RESOLVER_OVF_EN
  ,
  output logic                           ovf
`endif
);

  // Carry out of one beat is at most 2^(BIT_LEN-WORD_LEN), so one extra bit
  // beyond the redundant headroom is enough.
  localparam int CARRY_W = BIT_LEN - WORD_LEN + 1;
  localparam int IDX_W   = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [CARRY_W-1:0]   carry_q, carry_d;
  logic [BIT_LEN-1:0]   word_buf_q [NUM_WORDS];

  logic [BIT_LEN:0]     sum_s;
  logic                 in_fire_s;
  logic                 last_s;

  // Current word plus incoming carry; depends only on registered state.
  always_comb begin
    sum_s     = (BIT_LEN+1)'(word_buf_q[idx_q]) + (BIT_LEN+1)'(carry_q);
    in_fire_s = (state_q == IDLE) && in_valid;
    last_s    = (state_q == EMIT) && (idx_q == LAST_IDX);
  end

  // Next-state and output decode for the IDLE/EMIT controller.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    carry_d   = carry_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    out_word  = {WORD_LEN{1'b0}};
    out_last  = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = EMIT;
          idx_d   = {IDX_W{1'b0}};
          carry_d = {CARRY_W{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      EMIT: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        out_word  = sum_s[WORD_LEN-1:0];
        out_last  = last_s;
        if (out_ready) begin
          if (last_s) begin
            // Final carry is dropped here (reported via ovf when enabled).
            state_d = IDLE;
            idx_d   = {IDX_W{1'b0}};
            carry_d = {CARRY_W{1'b0}};
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            carry_d = sum_s[BIT_LEN:WORD_LEN];
          end
        end else begin
          state_d = EMIT;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = {IDX_W{1'b0}};
        carry_d = {CARRY_W{1'b0}};
      end
    endcase
  end

  // Controller state, word index and carry registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= {IDX_W{1'b0}};
      carry_q <= {CARRY_W{1'b0}};
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
    end
  end

  // Frame buffer; contents are don't-care until a frame is captured.
  always_ff @(posedge clk) begin
    if (in_fire_s) begin
      for (int j = 0; j < NUM_WORDS; j++) begin
        word_buf_q[j] <= in_words[BIT_LEN*j +: BIT_LEN];
      end
    end else begin
      for (int j = 0; j < NUM_WORDS; j++) begin
        word_buf_q[j] <= word_buf_q[j];
      end
    end
  end

`ifdef RESOLVER_OVF_EN
  logic out_last_fire_s;
  assign out_last_fire_s = last_s && out_ready;

  // Overflow flag: set from the final carry, cleared when a new frame starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (in_fire_s) begin
      ovf <= 1'b0;
    end else if (out_last_fire_s) begin
      ovf <= |sum_s[BIT_LEN:WORD_LEN];
    end else begin
      ovf <= ovf;
    end
  end
`endif

endmodule

// File: tb/tb_redundant_carry_resolver.sv
module tb_redundant_carry_resolver;

  localparam int NW = 34;
  localparam int BL = 17;
  localparam int WL = 16;
  localparam int MW = WL*NW + 8;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [NW*BL-1:0]  in_words;
  logic              out_valid;
  logic              out_ready;
  logic [WL-1:0]     out_word;
  logic              out_last;
  logic              busy;
`ifdef RESOLVER_OVF_EN
  logic              ovf;
`endif

  redundant_carry_resolver #(.NUM_WORDS(NW), .BIT_LEN(BL), .WORD_LEN(WL)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_words  (in_words),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .out_last  (out_last),
    .busy      (busy)
`ifdef RESOLVER_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [BL-1:0] frame    [NW];
  logic [WL-1:0] got_word [NW];
  logic          got_last [NW];
  int            n_beats;
  int            stall_bad;
  bit            timed_out;

  // Reference: the frame's value is simply the weighted sum of its words.
  function automatic logic [MW-1:0] model_value();
    logic [MW-1:0] v;
    v = '0;
    for (int j = 0; j < NW; j++) v = v + (MW'(frame[j]) << (WL*j));
    return v;
  endfunction

  function automatic logic [NW*BL-1:0] pack_frame();
    logic [NW*BL-1:0] p;
    for (int j = 0; j < NW; j++) p[BL*j +: BL] = frame[j];
    return p;
  endfunction

  // Present the current frame and wait for it to be accepted (called at a negedge).
  task automatic send_frame();
    bit ok;
    ok = 1'b0;
    in_words = pack_frame();
    in_valid = 1'b1;
    for (int c = 0; c < 100; c++) begin
      if (in_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_checks++;
    if (!ok) $display("FAIL send_timeout: in_ready never 1, required 1");
    else n_pass++;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Record output beats; mode 0 = always ready, mode 1 = 1,0,0,1 then random.
  task automatic collect(input int mode, input int max_beats);
    bit            prev_stall;
    logic [WL-1:0] prev_word;
    logic          prev_last;
    n_beats = 0; stall_bad = 0; timed_out = 1'b0; prev_stall = 1'b0;
    prev_word = '0; prev_last = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (mode == 0) out_ready = 1'b1;
      else if (cyc < 4) out_ready = (cyc == 0 || cyc == 3);
      else out_ready = 1'($urandom_range(0, 1));
      if (prev_stall && (out_valid !== 1'b1 || out_word !== prev_word || out_last !== prev_last))
        stall_bad++;
      prev_stall = (out_valid === 1'b1) && !out_ready;
      prev_word  = out_word;
      prev_last  = out_last;
      if (out_valid === 1'b1 && out_ready) begin
        if (n_beats < NW) begin
          got_word[n_beats] = out_word;
          got_last[n_beats] = out_last;
        end
        n_beats++;
        if (out_last === 1'b1 || n_beats >= max_beats) return;
      end
      @(negedge clk);
    end
    timed_out = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_words = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0 || out_word !== '0)
      $display("FAIL reset_outputs: got rdy=%b vld=%b last=%b busy=%b word=%h, required 1 0 0 0 0000",
               in_ready, out_valid, out_last, busy, out_word);
    else n_pass++;
`ifdef RESOLVER_OVF_EN
    n_checks++;
    if (ovf !== 1'b0) $display("FAIL reset_ovf: got %b required 0", ovf); else n_pass++;
`endif
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL reset_release: got rdy=%b vld=%b, required 1 0", in_ready, out_valid);
    else n_pass++;
  endtask

  task automatic test_patterns();
    logic [MW-1:0] exp;
    int            bad_last;
    for (int p = 0; p < 6; p++) begin
      for (int j = 0; j < NW; j++) begin
        case (p)
          0: frame[j] = '0;
          1: frame[j] = (j == 0) ? 17'h10000 : 17'h00000;
          2: frame[j] = 17'h1FFFF;
          default: frame[j] = 17'($urandom);
        endcase
      end
      exp = model_value();
      send_frame();
      n_checks++;
      if (out_valid !== 1'b1 || busy !== 1'b1)
        $display("FAIL pat%0d_first_valid: got vld=%b busy=%b, required 1 1", p, out_valid, busy);
      else n_pass++;
      collect(0, NW);
      n_checks++;
      if (timed_out || n_beats != NW)
        $display("FAIL pat%0d_beats: got %0d beats (timeout=%0d), required %0d", p, n_beats, timed_out, NW);
      else n_pass++;
      for (int k = 0; k < NW; k++) begin
        n_checks++;
        if (got_word[k] !== exp[WL*k +: WL])
          $display("FAIL pat%0d_word%0d: got %h required %h", p, k, got_word[k], exp[WL*k +: WL]);
        else n_pass++;
      end
      bad_last = 0;
      for (int k = 0; k < NW; k++) if (got_last[k] !== (k == NW-1)) bad_last++;
      n_checks++;
      if (bad_last != 0) $display("FAIL pat%0d_last: got %0d misplaced out_last, required 0", p, bad_last);
      else n_pass++;
      if (p == 2) begin
        n_checks++;
        if (got_word[0] !== 16'hFFFF || got_word[1] !== 16'h0000 || got_word[2] !== 16'h0001)
          $display("FAIL ones_head: got %h %h %h required ffff 0000 0001", got_word[0], got_word[1], got_word[2]);
        else n_pass++;
      end
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0)
        $display("FAIL pat%0d_idle: got rdy=%b busy=%b vld=%b required 1 0 0", p, in_ready, busy, out_valid);
      else n_pass++;
`ifdef RESOLVER_OVF_EN
      n_checks++;
      if (ovf !== (|exp[MW-1:WL*NW])) $display("FAIL pat%0d_ovf: got %b required %b", p, ovf, |exp[MW-1:WL*NW]);
      else n_pass++;
`endif
    end
  endtask

  task automatic test_multiplier();
    logic [MW-1:0] a, prod, want, got;
    logic [WL-1:0] d;
    bit            b_prev, b;
    a    = (MW'(1) << 272) - MW'(1);
    prod = a * a;
    want = (MW'(1) << 544) - (MW'(1) << 273) + MW'(1);
    // Spread the product into a redundant form with random inter-word borrows.
    b_prev = 1'b0;
    for (int j = 0; j < NW; j++) begin
      d = prod[WL*j +: WL];
      if (j == NW-1) b = 1'b0;
      else if (b_prev && d == '0) b = 1'b1;
      else b = 1'($urandom_range(0, 1));
      frame[j] = BL'(d) + (b ? 17'h10000 : 17'h00000) - BL'(b_prev);
      b_prev = b;
    end
    send_frame();
    collect(0, NW);
    got = '0;
    for (int k = 0; k < NW; k++) got[WL*k +: WL] = got_word[k];
    n_checks++;
    if (timed_out || n_beats != NW || got[WL*NW-1:0] !== want[WL*NW-1:0])
      $display("FAIL mult_result: got beats=%0d value=%h required %h", n_beats, got[WL*NW-1:0], want[WL*NW-1:0]);
    else n_pass++;
    @(negedge clk);
`ifdef RESOLVER_OVF_EN
    n_checks++;
    if (ovf !== 1'b0) $display("FAIL mult_ovf: got %b required 0", ovf); else n_pass++;
`endif
  endtask

  task automatic test_backpressure();
    logic [MW-1:0] exp;
    int            bad;
    int            seed_dummy;
    seed_dummy = $urandom(1);
    for (int j = 0; j < NW; j++) frame[j] = 17'h1FFFF;
    exp = model_value();
    send_frame();
    collect(1, NW);
    bad = 0;
    for (int k = 0; k < NW; k++) if (got_word[k] !== exp[WL*k +: WL]) bad++;
    n_checks++;
    if (timed_out || n_beats != NW || bad != 0)
      $display("FAIL stall_words: got beats=%0d wrong=%0d, required %0d 0", n_beats, bad, NW);
    else n_pass++;
    n_checks++;
    if (stall_bad != 0) $display("FAIL stall_hold: got %0d unstable stall cycles, required 0", stall_bad);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_frame();
    int extra;
    for (int j = 0; j < NW; j++) frame[j] = 17'($urandom);
    send_frame();
    collect(0, 11);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL midreset_during: got vld=%b busy=%b required 0 0", out_valid, busy);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL midreset_release: got rdy=%b vld=%b required 1 0", in_ready, out_valid);
    else n_pass++;
    extra = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid !== 1'b0) extra++;
    end
    n_checks++;
    if (extra != 0) $display("FAIL midreset_dropped: got %0d valid cycles, required 0", extra);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [BL-1:0] frame_b [NW];
    logic [MW-1:0] exp;
    int            bad;
    for (int j = 0; j < NW; j++) begin
      frame[j]   = 17'h1FFFF;
      frame_b[j] = 17'($urandom);
    end
    exp = model_value();
    in_words = pack_frame();
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    for (int j = 0; j < NW; j++) frame[j] = frame_b[j];
    in_words = pack_frame();
    collect(0, NW);
    bad = 0;
    for (int k = 0; k < NW; k++) if (got_word[k] !== exp[WL*k +: WL]) bad++;
    n_checks++;
    if (timed_out || n_beats != NW || bad != 0)
      $display("FAIL b2b_first: got beats=%0d wrong=%0d, required %0d 0", n_beats, bad, NW);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL b2b_gap: got vld=%b rdy=%b required 0 1", out_valid, in_ready);
    else n_pass++;
`ifdef RESOLVER_OVF_EN
    n_checks++;
    if (ovf !== 1'b1) $display("FAIL b2b_ovf_set: got %b required 1", ovf); else n_pass++;
`endif
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1) $display("FAIL b2b_restart: got vld=%b required 1", out_valid);
    else n_pass++;
`ifdef RESOLVER_OVF_EN
    n_checks++;
    if (ovf !== 1'b0) $display("FAIL b2b_ovf_clear: got %b required 0", ovf); else n_pass++;
`endif
    exp = model_value();
    collect(0, NW);
    bad = 0;
    for (int k = 0; k < NW; k++) if (got_word[k] !== exp[WL*k +: WL]) bad++;
    n_checks++;
    if (timed_out || n_beats != NW || bad != 0)
      $display("FAIL b2b_second: got beats=%0d wrong=%0d, required %0d 0", n_beats, bad, NW);
    else n_pass++;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_patterns();
    test_multiplier();
    test_backpressure();
    test_reset_mid_frame();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
